// File: rtl/wb_master_bridge_pkg.sv
// Shared encodings for the Wishbone master bridge: access sizes, FSM states
// and the alignment rule that decides whether a request ever reaches the bus.
package wb_master_bridge_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // True when the request must be answered with an error and no bus cycle.
    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b1;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/wb_master_bridge_lane_align.sv
// Big-endian byte-lane steering: byte enables and replicated write data toward
// the bus, and lane extraction plus sign/zero extension of returned load data.
module wbm_lane_align
    import wb_master_bridge_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        sext_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] bus_dat_i,
    output logic [3:0]  sel_o,
    output logic [31:0] dat_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        sel_o = 4'b0000;
        dat_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                sel_o = 4'b1000 >> off_i;
                dat_o = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                sel_o = off_i[1] ? 4'b0011 : 4'b1100;
                dat_o = {2{wdata_i[15:0]}};
            end
            SZ_WORD: begin
                sel_o = 4'b1111;
                dat_o = wdata_i;
            end
            default: begin
                sel_o = 4'b0000;
                dat_o = wdata_i;
            end
        endcase
    end

    // Byte offset 0 lives in the most significant lane.
    always_comb begin
        lane_b  = bus_dat_i[31:24];
        lane_h  = off_i[1] ? bus_dat_i[15:0] : bus_dat_i[31:16];
        rdata_o = 32'h0;
        case (off_i)
            2'd0:    lane_b = bus_dat_i[31:24];
            2'd1:    lane_b = bus_dat_i[23:16];
            2'd2:    lane_b = bus_dat_i[15:8];
            default: lane_b = bus_dat_i[7:0];
        endcase
        case (size_i)
            SZ_BYTE: rdata_o = {{24{sext_i & lane_b[7]}}, lane_b};
            SZ_HALF: rdata_o = {{16{sext_i & lane_h[15]}}, lane_h};
            SZ_WORD: rdata_o = bus_dat_i;
            default: rdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/wb_master_bridge.sv
// CPU load/store to classic single-beat Wishbone initiator, one transfer in flight.
// Define WBM_TIMEOUT_EN to abort a bus cycle left unacknowledged for TIMEOUT_CYCLES.
module wb_master_bridge
    import wb_master_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        sext_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        err_o,
    output logic        busy_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i
);

    logic [1:0]  state_q, state_d;
    logic        we_q, sext_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  sel_w;
    logic [31:0] dat_w, rdata_ext_w;
    logic        timeout_hit;

    wbm_lane_align u_align (
        .size_i    (size_q),
        .off_i     (addr_q[1:0]),
        .sext_i    (sext_q),
        .wdata_i   (wdata_q),
        .bus_dat_i (dat_i),
        .sel_o     (sel_w),
        .dat_o     (dat_w),
        .rdata_o   (rdata_ext_w)
    );

`ifdef WBM_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] to_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || state_d != ST_BUS) begin
            to_cnt_q <= '0;
        end else if (state_q == ST_BUS) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    // An ack on the terminal cycle still completes normally.
    assign timeout_hit = (state_q == ST_BUS) && !ack_i &&
                         (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            sext_q  <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req_i) begin
                we_q    <= we_i;
                size_q  <= size_i;
                sext_q  <= sext_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                err_q   <= req_bad(size_i, addr_i[1:0]);
                rdata_q <= 32'h0;
            end else if (state_q == ST_BUS) begin
                if (ack_i) begin
                    rdata_q <= we_q ? 32'h0 : rdata_ext_w;
                end else if (timeout_hit) begin
                    err_q   <= 1'b1;
                    rdata_q <= 32'h0;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_i) state_d = req_bad(size_i, addr_i[1:0]) ? ST_RESP : ST_BUS;
            ST_BUS:  if (ack_i || timeout_hit) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus outputs come only from state and request registers, never from req_i.
    always_comb begin
        cyc_o   = 1'b0;
        stb_o   = 1'b0;
        we_o    = 1'b0;
        sel_o   = 4'b0000;
        adr_o   = 32'h0;
        dat_o   = 32'h0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        err_o   = 1'b0;
        rdata_o = 32'h0;
        if (state_q == ST_BUS) begin
            cyc_o  = 1'b1;
            stb_o  = 1'b1;
            we_o   = we_q;
            sel_o  = sel_w;
            adr_o  = {addr_q[31:2], 2'b00};
            dat_o  = dat_w;
            busy_o = 1'b1;
        end
        if (state_q == ST_RESP) begin
            done_o  = 1'b1;
            err_o   = err_q;
            rdata_o = rdata_q;
        end
    end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Scoreboard bench for wb_master_bridge: stimulus queues expected bus and CPU
// responses from a byte-array model; a bus responder and a done monitor check them.
module tb_wb_master_bridge;

    localparam int TO = 8;
`ifdef WBM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [1:0]  size_i = 2'd0;
    logic        sext_i = 1'b0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic [31:0] dat_i = 32'h0;
    logic        ack_i = 1'b0;
    logic [31:0] rdata_o, adr_o, dat_o;
    logic        done_o, err_o, busy_o, cyc_o, stb_o, we_o;
    logic [3:0]  sel_o;

    wb_master_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
        .sext_i(sext_i), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
        .done_o(done_o), .err_o(err_o), .busy_o(busy_o), .cyc_o(cyc_o), .stb_o(stb_o),
        .we_o(we_o), .sel_o(sel_o), .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i),
        .ack_i(ack_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc_cnt = 0;
    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] din;
        int          waits;
        bit          noack;
    } plan_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          req_cnt;
        int          lat;
    } resp_t;

    plan_t plan_q[$];
    resp_t resp_q[$];
    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: treat the word as four big-endian bytes.
    function automatic int nbytes(input logic [1:0] size);
        return 1 << size;
    endfunction

    function automatic bit m_bad(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd3) return 1'b1;
        return (addr % nbytes(size)) != 0;
    endfunction

    function automatic logic [3:0] m_sel(input logic [1:0] size, input logic [31:0] addr);
        logic [3:0] s;
        int off;
        s = 4'b0;
        off = int'(addr % 4);
        for (int k = off; k < off + nbytes(size); k++) s[3-k] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] m_dat(input logic [1:0] size, input logic [31:0] w);
        logic [31:0] d;
        int n;
        n = nbytes(size);
        d = 32'h0;
        for (int i = 0; i < 4; i++) d[8*i +: 8] = w[8*(i % n) +: 8];
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic [31:0] addr,
                                           input bit sext, input logic [31:0] d);
        int n, off;
        logic [31:0] mask, v;
        n = nbytes(size);
        off = int'(addr % 4);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*n)) - 1);
        v = (d >> (8*(4 - off - n))) & mask;
        if (sext && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic issue(input bit we, input logic [1:0] size, input bit sext,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] din, input int waits, input bit noack,
                         input int hold);
        plan_t p;
        resp_t r;
        bit bad;
        bad = m_bad(size, addr);
        @(negedge clk_i);
        we_i = we; size_i = size; sext_i = sext; addr_i = addr; wdata_i = wdata;
        req_i = 1'b1;
        if (!bad) begin
            p.adr = addr & 32'hFFFF_FFFC;
            p.dat = m_dat(size, wdata);
            p.sel = m_sel(size, addr);
            p.we = we;
            p.din = din;
            p.waits = waits;
            p.noack = noack;
            plan_q.push_back(p);
        end
        r.err = bad || noack;
        r.rdata = (r.err || we) ? 32'h0 : m_load(size, addr, sext, din);
        r.req_cnt = cyc_cnt;
        r.lat = bad ? 1 : (noack ? 1 + TO : 2 + waits);
        if (!(noack && !TO_EN)) resp_q.push_back(r);
        repeat (hold) @(negedge clk_i);
        req_i = 1'b0;
        we_i = $urandom; size_i = 2'($urandom); sext_i = $urandom;
        addr_i = $urandom; wdata_i = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (resp_q.size() != 0 && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        chk("drain_bound", 32'(resp_q.size()), 32'd0);
        resp_q.delete();
        @(negedge clk_i);
    endtask

    // Bus-side responder: checks the presented cycle against the plan every cycle.
    bit    rsp_active = 1'b0;
    plan_t rsp_cur;
    int    rsp_wcnt = 0;
    always @(negedge clk_i) begin
        ack_i = 1'b0;
        if (rst_i) begin
            rsp_active = 1'b0;
        end else if (cyc_o && stb_o) begin
            if (!rsp_active) begin
                if (plan_q.size() == 0) begin
                    chk("unexpected_cyc", 32'd1, 32'd0);
                    rsp_cur = '{default: 0};
                    rsp_cur.noack = 1'b1;
                end else begin
                    rsp_cur = plan_q.pop_front();
                end
                rsp_active = 1'b1;
                rsp_wcnt = 0;
            end
            chk("adr_o", adr_o, rsp_cur.adr);
            chk("sel_o", 32'(sel_o), 32'(rsp_cur.sel));
            chk("we_o", 32'(we_o), 32'(rsp_cur.we));
            if (rsp_cur.we) chk("dat_o", dat_o, rsp_cur.dat);
            if (!rsp_cur.noack && rsp_wcnt == rsp_cur.waits) begin
                ack_i = 1'b1;
                dat_i = rsp_cur.din;
                rsp_active = 1'b0;
            end else begin
                rsp_wcnt++;
                dat_i = $urandom;
            end
        end else begin
            rsp_active = 1'b0;
            ack_i = ($urandom_range(0, 3) == 0);
            dat_i = $urandom;
        end
    end

    resp_t mon_r;
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (done_o) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_r = resp_q.pop_front();
                    chk("rdata_o", rdata_o, mon_r.rdata);
                    chk("err_o", 32'(err_o), 32'(mon_r.err));
                    chk("latency", 32'(cyc_cnt - mon_r.req_cnt), 32'(mon_r.lat));
                    chk("busy_in_resp", 32'(busy_o), 32'd0);
                end
            end else if (err_o) begin
                chk("err_without_done", 32'd1, 32'd0);
            end
        end
    end

    initial begin
        bit we, sx, na;
        logic [1:0] sz;
        logic [31:0] ad;
        repeat (3) @(negedge clk_i);
        chk("rst_cyc", 32'(cyc_o), 32'd0);
        chk("rst_stb", 32'(stb_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_sel", 32'(sel_o), 32'd0);
        chk("rst_adr", adr_o, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        rst_i = 1'b0;

        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1'b0, 1); wait_idle();
        issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h34, 32'h0, 1, 1'b0, 1); wait_idle();
        issue(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 32'h80123456, 0, 1'b0, 1); wait_idle();
        issue(1'b0, 2'd1, 1'b0, 32'h02, 32'h0, 32'h1234ABCD, 5, 1'b0, 1); wait_idle();
        issue(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 32'h0, 0, 1'b0, 1); wait_idle();
        issue(1'b0, 2'd3, 1'b1, 32'h08, 32'h0, 32'h0, 0, 1'b0, 2); wait_idle();
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, TO - 1, 1'b0, 1); wait_idle();

        issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h0, 0, 1'b1, 1);
        if (TO_EN) begin
            wait_idle();
        end else begin
            repeat (20) @(negedge clk_i);
            chk("hang_busy", 32'(busy_o), 32'd1);
            chk("hang_cyc", 32'(cyc_o), 32'd1);
        end

        if (!busy_o) issue(1'b1, 2'd2, 1'b0, 32'h44, 32'h11223344, 32'h0, 0, 1'b1, 1);
        repeat (2) @(negedge clk_i);
        chk("pre_rst_busy", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("midrst_cyc", 32'(cyc_o), 32'd0);
        chk("midrst_stb", 32'(stb_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_done", 32'(done_o), 32'd0);
        plan_q.delete();
        resp_q.delete();
        rst_i = 1'b0;
        issue(1'b0, 2'd1, 1'b1, 32'h46, 32'h0, 32'h0000F00F, 2, 1'b0, 1); wait_idle();

        for (int i = 0; i < 60; i++) begin
            we = $urandom;
            sx = $urandom;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ad = $urandom;
            if ($urandom_range(0, 2) != 0) ad = ad & ~(32'(nbytes(sz)) - 1);
            na = 1'b0;
            issue(we, sz, sx, ad, $urandom, $urandom, $urandom_range(0, 5), na, 1);
            wait_idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "global timeout");
    end

endmodule
